load_store_unit: RTL and testbench
==================================

# load_store_unit

Multicycle data-memory access unit for the RV32I core. It takes an effective address (ALU result) and store data (rs2) from the datapath when ControlFSM enters its memory-access state. It issues one word-aligned request on a req/ack memory port and waits any number of cycles for the memory. It then returns a sign- or zero-extended load value, or a byte-laned store, and pulses `done` so the FSM can advance to writeback or fetch.

## Interface
- `TIMEOUT_CYCLES`, default 255: ACCESS cycles without `mem_ack` before the transaction is aborted with `err`. Legal range 1..65535.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a transaction; sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load; sampled with `start`.
- `funct3` in 3: instr[14:12]; sampled with `start`.
- `addr` in 32: byte address; sampled with `start`.
- `store_data` in 32: rs2 value; sampled with `start`.
- `load_data` out 32: extended load result; registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; misaligned access, illegal funct3, or timeout.
- `mem_req` out 1: request; held until acknowledged.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: word address, `{addr[31:2], 2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte enables; 0000 for loads.
- `mem_rdata` in 32: read word; valid when `mem_ack` is high.
- `mem_ack` in 1: completes the request in any cycle where `mem_req` is also high.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE → ACCESS on `start` with a legal, aligned operation. Capture `is_store`, `funct3`, `addr[1:0]`, `mem_addr`, `mem_wdata`, `mem_wstrb`; clear the timeout counter.
- IDLE → DONE with `err`=1 on `start` with an illegal or misaligned operation. `mem_req` is never raised.
  - Illegal funct3 for a load: anything other than 000, 001, 010, 100, 101.
  - Illegal funct3 for a store: anything other than 000, 001, 010.
  - Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠00.
- ACCESS behaviour:
  - `mem_req`=1 while in ACCESS.
  - On `mem_ack` → DONE with `err`=0. For loads, `load_data` is updated on that edge.
  - Timeout counter increments each ACCESS cycle without ack. When it reaches TIMEOUT_CYCLES → DONE with `err`=1; `load_data` is unchanged.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- `start` outside IDLE is ignored; there is no queueing. `mem_ack` outside ACCESS is ignored.
- Store lanes, with b = `addr[1:0]`:
  - SB: wdata = {4{sd[7:0]}}, wstrb = 0001 << b.
  - SH: wdata = {2{sd[15:0]}}, wstrb = 0011 << (2·`addr[1]`).
  - SW: wdata = sd, wstrb = 1111.
- Load extraction, from `mem_rdata` shifted right by 8·b:
  - LB: sign-extend bits [7:0].
  - LBU: zero-extend bits [7:0].
  - LH: sign-extend bits [15:0].
  - LHU: zero-extend bits [15:0].
  - LW: whole word.
- `load_data` holds its value until the next successful load, including across stores and errors.

## Timing
- Reset values: state IDLE; all outputs 0; `load_data` = 0; timeout counter 0. Reset in any state aborts the transaction with no `done`. `mem_req` is low in the cycle after the reset edge.
- Zero-wait memory (ack in the first ACCESS cycle):
  - `start` sampled at edge E0.
  - `mem_req` high in E0–E1.
  - `load_data` and `done` valid in E1–E2.
  - Start to `done` is 2 cycles.
- Each wait cycle adds 1. `busy` is high from E0 until the edge that ends DONE.
- `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb` are registered and stable for the whole ACCESS state.
- Error on `start`: `done` and `err` high in E0–E1; 1 cycle latency.
- Timeout: with `mem_ack` held low, `done` and `err` appear TIMEOUT_CYCLES+1 cycles after `start`.
- `mem_ack` on the same edge the counter reaches TIMEOUT_CYCLES: ack wins, `err`=0.
- `start` during the DONE cycle is ignored. A new transaction may start the cycle `busy` falls.

## Test plan
- LB at addr 0x103, rdata 0x80FF_1234, zero-wait → `mem_addr`=0x100, `wstrb`=0000, `load_data`=0xFFFF_FF80, `done` 2 cycles after `start`, `err`=0.
- SH at addr 0x202, `store_data`=0xDEAD_BEEF, ack after 3 wait cycles → `wdata`=0xBEEF_BEEF, `wstrb`=1100, `mem_we`=1, signals stable for 4 req cycles, `done` 5 cycles after `start`.
- LW at addr 0x006 → no `mem_req`; `done`=`err`=1 one cycle after `start`; `load_data` unchanged.
- LHU at 0x00A with TIMEOUT_CYCLES=4 and `mem_ack` tied low → `mem_req` high for 4 cycles, then `done`=`err`=1, `busy` falls.
- Reset asserted in the second ACCESS cycle of an SW → `mem_req`=0 and `busy`=0 after the edge, no `done`; an LBU at 0x001 with rdata 0x0000_9A00 then returns 0x0000_009A.
- `start` pulsed every cycle during a 2-wait LW → exactly one transaction and one `done`; extra starts are ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Multicycle data-memory access unit: one word-aligned req/ack transaction per start,
// with byte-laned stores, sign/zero-extended loads, and misalignment/illegal/timeout errors.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [1:0]  boff;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } lsu_req_t;

   logic [1:0]  state;
   lsu_req_t    req_d, req_q;
   logic        legal, aligned;
   logic [15:0] tmo_cnt;
   logic [16:0] tmo_nxt;
   logic [31:0] rshift, ld_ext;

   always_comb begin
      req_d        = '0;
      req_d.we     = is_store;
      req_d.funct3 = funct3;
      req_d.boff   = addr[1:0];
      req_d.addr   = {addr[31:2], 2'b00};
      case (funct3[1:0])
         2'b00: begin
            req_d.wdata = {4{store_data[7:0]}};
            req_d.wstrb = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            req_d.wdata = {2{store_data[15:0]}};
            req_d.wstrb = 4'b0011 << {addr[1], 1'b0};
         end
         default: begin
            req_d.wdata = store_data;
            req_d.wstrb = 4'b1111;
         end
      endcase
      // Loads never drive byte enables.
      if (!is_store) begin
         req_d.wdata = '0;
         req_d.wstrb = '0;
      end
   end

   always_comb begin
      if (is_store) legal = funct3 inside {3'b000, 3'b001, 3'b010};
      else          legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      case (funct3[1:0])
         2'b01:   aligned = !addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   always_comb begin
      rshift = mem_rdata >> {req_q.boff, 3'b000};
      case (req_q.funct3)
         3'b000:  ld_ext = {{24{rshift[7]}}, rshift[7:0]};
         3'b100:  ld_ext = {24'b0, rshift[7:0]};
         3'b001:  ld_ext = {{16{rshift[15]}}, rshift[15:0]};
         3'b101:  ld_ext = {16'b0, rshift[15:0]};
         default: ld_ext = rshift;
      endcase
   end

   assign tmo_nxt = {1'b0, tmo_cnt} + 17'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         req_q     <= '0;
         tmo_cnt   <= '0;
         load_data <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (legal && aligned) begin
                     req_q   <= req_d;
                     tmo_cnt <= '0;
                     err     <= 1'b0;
                     state   <= S_ACCESS;
                  end else begin
                     err   <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_ACCESS: begin
               // An ack on the same edge as the timeout takes priority.
               if (mem_ack) begin
                  if (!req_q.we) load_data <= ld_ext;
                  err   <= 1'b0;
                  state <= S_DONE;
               end else if (tmo_nxt == 17'(TIMEOUT_CYCLES)) begin
                  err   <= 1'b1;
                  state <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_nxt[15:0];
               end
            end
            S_DONE: begin
               err   <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign mem_req   = (state == S_ACCESS);
   assign mem_we    = req_q.we;
   assign mem_addr  = req_q.addr;
   assign mem_wdata = req_q.wdata;
   assign mem_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a scoreboard of expected completions is filled when
// a start is driven and drained by a monitor that watches done.
module tb_load_store_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset, start, is_store, mem_ack;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data, mem_rdata;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        busy, done, err, mem_req, mem_we;

   load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
      .addr(addr), .store_data(store_data), .load_data(load_data), .busy(busy),
      .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] ld;
      logic        er;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [31:0] last_ld;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Completion monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done === 1'b1) begin
         check("done_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            check("done_load_data", load_data, e.ld);
            check("done_err", 32'(err), 32'(e.er));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int lat, input logic [31:0] eld,
                        input logic eer, input bit push);
      exp_t e;
      start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
      if (push) begin
         e.cyc = cyc + lat; e.ld = eld; e.er = eer;
         sb.push_back(e);
      end
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = '0;
      store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
      tick(); tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_wstrb", 32'(mem_wstrb), 32'd0);
      check("rst_load_data", load_data, 32'd0);
      reset = 1'b0;
      last_ld = 32'd0;
      tick();

      // LB 0x103, zero-wait; ack held high while idle must be ignored.
      mem_rdata = 32'h80FF_1234; mem_ack = 1'b1;
      tick();
      check("idle_ack_ignored", 32'(busy), 32'd0);
      issue(1'b0, 3'b000, 32'h103, 32'h0, 2, 32'hFFFF_FF80, 1'b0, 1'b1);
      check("lb_req", 32'(mem_req), 32'd1);
      check("lb_addr", mem_addr, 32'h100);
      check("lb_wstrb", 32'(mem_wstrb), 32'd0);
      check("lb_we", 32'(mem_we), 32'd0);
      tick();
      mem_ack = 1'b0;
      check("lb_req_drop", 32'(mem_req), 32'd0);
      last_ld = 32'hFFFF_FF80;
      tick();

      // SH 0x202, three wait cycles; ack lands on the timeout edge and must win.
      issue(1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 5, last_ld, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("sh_req", 32'(mem_req), 32'd1);
         check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
         check("sh_wstrb", 32'(mem_wstrb), 32'b1100);
         check("sh_we", 32'(mem_we), 32'd1);
         if (i == 3) mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      check("sh_busy_done", 32'(busy), 32'd1);
      tick();
      check("sh_busy_fall", 32'(busy), 32'd0);

      // SB 0x003, zero-wait.
      mem_ack = 1'b1;
      issue(1'b1, 3'b000, 32'h003, 32'h0000_00A5, 2, last_ld, 1'b0, 1'b1);
      check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      check("sb_wstrb", 32'(mem_wstrb), 32'b1000);
      tick();
      mem_ack = 1'b0;
      tick();

      // LH 0x102, zero-wait, upper halfword with sign bit set.
      mem_rdata = 32'h8001_0000; mem_ack = 1'b1;
      issue(1'b0, 3'b001, 32'h102, 32'h0, 2, 32'hFFFF_8001, 1'b0, 1'b1);
      tick();
      mem_ack = 1'b0;
      last_ld = 32'hFFFF_8001;
      tick();

      // Misaligned LW 0x006: no request, error after one cycle.
      issue(1'b0, 3'b010, 32'h006, 32'h0, 1, last_ld, 1'b1, 1'b1);
      check("lw_mis_req", 32'(mem_req), 32'd0);
      check("lw_mis_busy", 32'(busy), 32'd1);
      tick();
      check("lw_mis_idle", 32'(busy), 32'd0);

      // Illegal store funct3 (100).
      issue(1'b1, 3'b100, 32'h000, 32'h0, 1, last_ld, 1'b1, 1'b1);
      check("ill_req", 32'(mem_req), 32'd0);
      tick();

      // LHU 0x00A with ack tied low: timeout after TMO request cycles.
      issue(1'b0, 3'b101, 32'h00A, 32'h0, TMO + 1, last_ld, 1'b1, 1'b1);
      for (int i = 0; i < TMO; i++) begin
         check("tmo_req", 32'(mem_req), 32'd1);
         check("tmo_addr", mem_addr, 32'h008);
         tick();
      end
      check("tmo_req_drop", 32'(mem_req), 32'd0);
      check("tmo_busy", 32'(busy), 32'd1);
      tick();
      check("tmo_busy_fall", 32'(busy), 32'd0);

      // SW aborted by reset in its second ACCESS cycle: no done.
      issue(1'b1, 3'b010, 32'h010, 32'h1234_5678, 0, 32'h0, 1'b0, 1'b0);
      check("sw_wdata", mem_wdata, 32'h1234_5678);
      check("sw_wstrb", 32'(mem_wstrb), 32'b1111);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_abort_req", 32'(mem_req), 32'd0);
      check("rst_abort_busy", 32'(busy), 32'd0);
      check("rst_abort_ld", load_data, 32'd0);

      // LBU 0x001 after the abort.
      mem_rdata = 32'h0000_9A00; mem_ack = 1'b1;
      issue(1'b0, 3'b100, 32'h001, 32'h0, 2, 32'h0000_009A, 1'b0, 1'b1);
      tick();
      mem_ack = 1'b0;
      last_ld = 32'h0000_009A;
      tick();

      // LW 0x040, two waits, start held through ACCESS and DONE.
      mem_rdata = 32'hCAFE_F00D;
      issue(1'b0, 3'b010, 32'h040, 32'h0, 4, 32'hCAFE_F00D, 1'b0, 1'b1);
      start = 1'b1;
      tick();
      check("lw_hold_addr", mem_addr, 32'h040);
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      start = 1'b0;
      check("lw_hold_idle", 32'(busy), 32'd0);
      tick();
      check("lw_hold_no_restart", 32'(busy), 32'd0);
      check("lw_hold_ld", load_data, 32'hCAFE_F00D);

      tick(); tick();
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
